// File: rtl/drink_vend_pkg.sv
// Shared types and helpers for the drink vending controller.
// Optional debounce filtering is enabled by defining DRINK_VEND_DEBOUNCE_EN.
package drink_vend_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SELECT   = 2'd1,
      DISPENSE = 2'd2
   } state_t;

   localparam int MAX_ITEMS = 8;

   // LEDs are active-low, so "all off" is all ones.
   localparam logic [MAX_ITEMS-1:0] LEDS_OFF = '1;

   // Bits needed to hold the values 0..n-1 (never less than one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/drink_vend_ctrl_btn_debounce.sv
// Button front end: two-flop synchronizer, optional debounce filter
// (DRINK_VEND_DEBOUNCE_EN), and a registered falling-edge press detector.
module btn_debounce
   import drink_vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic press
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
   end

   logic sync1;
   logic sync2;
   logic filt;
   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

`ifdef DRINK_VEND_DEBOUNCE_EN
   localparam int CW = cnt_width(DEBOUNCE_CYCLES);

   logic [CW-1:0] cnt;
   logic          filt_q;

   // The filtered level flips only after DEBOUNCE_CYCLES consecutive
   // samples that disagree with it; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         filt_q <= 1'b1;
      end else if (sync2 == filt_q) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         cnt    <= '0;
         filt_q <= sync2;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign filt = filt_q;
`else
   assign filt = sync2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         prev  <= 1'b1;
         press <= 1'b0;
      end else begin
         prev  <= filt;
         press <= prev & ~filt;
      end
   end

   // Level is taken from the edge register so it lines up with press.
   assign level = prev;

endmodule

// File: rtl/drink_vend_ctrl.sv
// Drink vending controller: select/buy buttons drive an IDLE/SELECT/DISPENSE FSM.
// Define DRINK_VEND_DEBOUNCE_EN to add debounce filtering on both buttons.
module drink_vend_ctrl
   import drink_vend_pkg::*;
#(
   parameter int N_ITEMS         = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DISPENSE_CYCLES = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             btn1,
   input  logic                             btn2,
   output logic [N_ITEMS-1:0]               lights,
   output logic [cnt_width(N_ITEMS+1)-1:0]  sel_idx,
   output logic                             dispensing,
   output logic                             vend_done,
   output state_t                           dbg_state
);

   localparam int SEL_W = cnt_width(N_ITEMS + 1);
   localparam int TMR_W = cnt_width(DISPENSE_CYCLES);
   localparam bit BLINK = (DISPENSE_CYCLES >= 2);

   if (N_ITEMS < 2 || N_ITEMS > MAX_ITEMS || DISPENSE_CYCLES < 1) begin : g_bad_params
      $error("drink_vend_ctrl: parameter out of range");
   end

   logic lvl1, lvl2, press1, press2;
   logic cancel, sel_ev, buy_ev;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn1),
      .level (lvl1),
      .press (press1)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn2 (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn2),
      .level (lvl2),
      .press (press2)
   );

   // Both buttons held together is a cancel and masks any press.
   assign cancel = ~lvl1 & ~lvl2;
   assign sel_ev = press1 & ~cancel;
   assign buy_ev = press2 & ~cancel;

   function automatic logic [N_ITEMS-1:0] led_for(input logic [SEL_W-1:0] s);
      led_for = LEDS_OFF[N_ITEMS-1:0];
      for (int i = 0; i < N_ITEMS; i++) begin
         if (s == SEL_W'(i + 1)) led_for[i] = 1'b0;
      end
   endfunction

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [N_ITEMS-1:0] lights_d;
   logic               disp_d;
   logic               vd_d;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_idx;
      tmr_d    = tmr_q;
      lights_d = lights;
      disp_d   = dispensing;
      vd_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_ev) begin
               state_d  = SELECT;
               sel_d    = SEL_W'(1);
               lights_d = led_for(SEL_W'(1));
            end
         end
         SELECT: begin
            if (cancel) begin
               state_d  = IDLE;
               sel_d    = '0;
               lights_d = LEDS_OFF[N_ITEMS-1:0];
            end else if (buy_ev) begin
               state_d = DISPENSE;
               tmr_d   = TMR_W'(DISPENSE_CYCLES - 1);
               disp_d  = 1'b1;
            end else if (sel_ev) begin
               sel_d    = (sel_idx == SEL_W'(N_ITEMS)) ? SEL_W'(1) : sel_idx + SEL_W'(1);
               lights_d = led_for(sel_d);
            end
         end
         DISPENSE: begin
            if (cancel || tmr_q == '0) begin
               state_d  = IDLE;
               sel_d    = '0;
               lights_d = LEDS_OFF[N_ITEMS-1:0];
               disp_d   = 1'b0;
               vd_d     = ~cancel;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
               // Blink by flipping only the selected LED each cycle.
               if (BLINK) lights_d = lights ^ ~led_for(sel_idx);
            end
         end
         default: begin
            state_d  = IDLE;
            sel_d    = '0;
            lights_d = LEDS_OFF[N_ITEMS-1:0];
            disp_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_idx    <= '0;
         tmr_q      <= '1;
         lights     <= LEDS_OFF[N_ITEMS-1:0];
         dispensing <= 1'b0;
         vend_done  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_idx    <= sel_d;
         tmr_q      <= tmr_d;
         lights     <= lights_d;
         dispensing <= disp_d;
         vend_done  <= vd_d;
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_drink_vend_ctrl.sv
// Scoreboard bench for drink_vend_ctrl: every output change is matched
// against an expected value and the cycle in which it must appear.
module tb_drink_vend_ctrl;
   import drink_vend_pkg::*;

`ifdef DRINK_VEND_DEBOUNCE_EN
   localparam int LAT = 8;
`else
   localparam int LAT = 4;
`endif
   localparam int HOLD = 6;
   localparam int GAP  = 14;

   // Active-low LED patterns indexed by selection (0 = none).
   localparam logic [2:0] LED_TAB [4] = '{3'b111, 3'b110, 3'b101, 3'b011};

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       btn1 = 1'b1;
   logic       btn2 = 1'b1;
   logic [2:0] lights;
   logic [1:0] sel_idx;
   logic       dispensing;
   logic       vend_done;
   state_t     dbg_state;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic        mon_en = 1'b0;
   logic [8:0]  last_obs;
   logic [24:0] exp_q[$];

   drink_vend_ctrl #(
      .N_ITEMS         (3),
      .DEBOUNCE_CYCLES (4),
      .DISPENSE_CYCLES (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn1       (btn1),
      .btn2       (btn2),
      .lights     (lights),
      .sel_idx    (sel_idx),
      .dispensing (dispensing),
      .vend_done  (vend_done),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers / driver tasks ----------------
   function automatic logic [8:0] pk(input state_t s, input logic [1:0] sel,
                                     input logic [2:0] l, input logic d, input logic v);
      return {s, sel, l, d, v};
   endfunction

   function automatic logic [8:0] obs();
      return {dbg_state, sel_idx, lights, dispensing, vend_done};
   endfunction

   task automatic expect_at(input int c, input logic [8:0] v);
      logic [15:0] c16;
      c16 = c[15:0];
      exp_q.push_back({c16, v});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int which, input int hold);
      if (which[0]) btn1 = 1'b0;
      if (which[1]) btn2 = 1'b0;
      step(hold);
      if (which[0]) btn1 = 1'b1;
      if (which[1]) btn2 = 1'b1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [8:0]  cur;
      logic [24:0] e;
      if (mon_en) begin
         cur = obs();
         if (cur !== last_obs) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change got=%h at cycle %0d", cur, cyc);
            end else begin
               e = exp_q.pop_front();
               if (e[8:0] !== cur || e[24:9] != cyc[15:0]) begin
                  bad++;
                  $display("FAIL out_change got=%h@%0d exp=%h@%0d", cur, cyc, e[8:0], e[24:9]);
               end
            end
            last_obs = cur;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int s;

      step(3);
      check("rst_state", dbg_state, IDLE);
      check("rst_sel", sel_idx, 0);
      check("rst_lights", lights, 3'b111);
      check("rst_disp", dispensing, 0);
      check("rst_vdone", vend_done, 0);
      last_obs = obs();
      mon_en   = 1'b1;
      rst      = 1'b0;
      step(2);

      // Four selects: 1, 2, 3, then wrap to 1.
      for (int i = 1; i <= 4; i++) begin
         s = (i - 1) % 3 + 1;
         k = cyc;
         expect_at(k + LAT, pk(SELECT, s[1:0], LED_TAB[s], 1'b0, 1'b0));
         press(1, HOLD);
         step(GAP);
      end

      // Select 2, then buy: 8 dispense cycles with blink, then vend_done pulse.
      k = cyc;
      expect_at(k + LAT, pk(SELECT, 2'd2, LED_TAB[2], 1'b0, 1'b0));
      press(1, HOLD);
      step(GAP);
      k = cyc;
      for (int i = 0; i < 8; i++)
         expect_at(k + LAT + i, pk(DISPENSE, 2'd2, (i % 2 == 0) ? LED_TAB[2] : 3'b111, 1'b1, 1'b0));
      expect_at(k + LAT + 8, pk(IDLE, 2'd0, 3'b111, 1'b0, 1'b1));
      expect_at(k + LAT + 9, pk(IDLE, 2'd0, 3'b111, 1'b0, 1'b0));
      press(2, HOLD);
      step(GAP + LAT);

      // Buy while idle is ignored.
      press(2, HOLD);
      step(GAP);
      check("idle_buy_state", dbg_state, IDLE);
      check("idle_buy_lights", lights, 3'b111);
      check("idle_buy_sel", sel_idx, 0);

      // Cancel during dispense: btn2 kept low, btn1 joins it.
      k = cyc;
      expect_at(k + LAT, pk(SELECT, 2'd1, LED_TAB[1], 1'b0, 1'b0));
      press(1, HOLD);
      step(GAP);
      k = cyc;
      expect_at(k + LAT,     pk(DISPENSE, 2'd1, LED_TAB[1], 1'b1, 1'b0));
      expect_at(k + LAT + 1, pk(DISPENSE, 2'd1, 3'b111,     1'b1, 1'b0));
      expect_at(k + LAT + 2, pk(IDLE,     2'd0, 3'b111,     1'b0, 1'b0));
      btn2 = 1'b0;
      step(2);
      btn1 = 1'b0;
      step(HOLD + 4);
      btn1 = 1'b1;
      btn2 = 1'b1;
      step(GAP + LAT);

      // Reset in the middle of a dispense aborts it without vend_done.
      k = cyc;
      expect_at(k + LAT, pk(SELECT, 2'd1, LED_TAB[1], 1'b0, 1'b0));
      press(1, HOLD);
      step(GAP);
      k = cyc;
      expect_at(k + LAT, pk(SELECT, 2'd2, LED_TAB[2], 1'b0, 1'b0));
      press(1, HOLD);
      step(GAP);
      k = cyc;
      expect_at(k + LAT,     pk(DISPENSE, 2'd2, LED_TAB[2], 1'b1, 1'b0));
      expect_at(k + LAT + 1, pk(DISPENSE, 2'd2, 3'b111,     1'b1, 1'b0));
      btn2 = 1'b0;
      step(LAT + 1);
      expect_at(cyc + 1, pk(IDLE, 2'd0, 3'b111, 1'b0, 1'b0));
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(2);
      btn2 = 1'b1;
      step(GAP + LAT + 10);

`ifdef DRINK_VEND_DEBOUNCE_EN
      // A 3-cycle glitch is filtered out; a 6-cycle press selects item 1.
      press(1, 3);
      step(GAP);
      k = cyc;
      expect_at(k + 8, pk(SELECT, 2'd1, LED_TAB[1], 1'b0, 1'b0));
      press(1, 6);
      step(GAP);
`endif

      check("queue_drained", exp_q.size(), 0);
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/drink_vend_ctrl.md
DRINK_VEND_CTRL -- requirements
Module: drink_vend_ctrl

Interface
REQ-001 Parameter N_ITEMS, default 3: number of products, legal range 2..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: number of stable cycles required before a filtered button level changes.
REQ-003 Parameter DISPENSE_CYCLES, default 8: duration of the dispense indication, in cycles.
REQ-004 clk  in  1  sole clock; everything is on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 btn1  in  1  select button, active-low, asynchronous to clk.
REQ-007 btn2  in  1  buy button, active-low, asynchronous to clk.
REQ-008 lights  out  N_ITEMS  product LEDs, active-low, at most one bit low.
REQ-009 sel_idx  out  $clog2(N_ITEMS+1)  current selection; 0 means no selection.
REQ-010 dispensing  out  1  high while the FSM is in DISPENSE.
REQ-011 vend_done  out  1  single-cycle pulse when a dispense completes normally.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer, then the filter defined in REQ-026/027, to give a filtered active-low level.
REQ-013 Press events:
- A press event is a filtered 1->0 transition, registered once per press.
- Holding a button SHALL NOT repeat the event.
REQ-014 Cancel:
- Cancel is both filtered levels low in the same cycle.
- Cancel overrides all other events.
- While both buttons are low, no select or buy event SHALL register.
REQ-015 FSM states: IDLE, SELECT, DISPENSE.
REQ-016 IDLE:
- A select event sets sel_idx=1 and moves to SELECT.
- A buy event is ignored.
REQ-017 SELECT, select event: sel_idx increments 1..N_ITEMS, wrapping N_ITEMS->1 and never passing through 0.
REQ-018 SELECT, buy event:
- Load the dispense timer with DISPENSE_CYCLES-1.
- Move to DISPENSE.
- sel_idx is held.
REQ-019 DISPENSE:
- The timer decrements once per cycle.
- Select and buy events are ignored.
- At timer==0: pulse vend_done for one cycle, clear sel_idx to 0, go to IDLE.
REQ-020 Cancel in SELECT or DISPENSE:
- Next cycle: sel_idx=0, lights all 1, dispensing=0, state IDLE.
- vend_done SHALL NOT pulse.
REQ-021 Lights mapping:
- In SELECT, lights[sel_idx-1]=0 and all other bits are 1.
- In DISPENSE, the same bit is low; it also toggles every cycle when DISPENSE_CYCLES>=2, to give a blink.
- In IDLE, lights are all 1.
REQ-022 All outputs SHALL be registered; an FSM state change is visible on its outputs the cycle after the event.
REQ-023 Latency, macro undefined: button pin change to output change is exactly 4 cycles (2 sync, 1 edge register, 1 output register).

Reset
REQ-024 On rst high at a clk edge:
- state=IDLE, sel_idx=0, lights all 1, dispensing=0, vend_done=0.
- Timer, synchronizers and filters are set to the released level (1).
REQ-025 Reset asserted mid-dispense SHALL abort it with no vend_done pulse; reset dominates every other input.

Configuration
REQ-026 With DRINK_VEND_DEBOUNCE_EN defined:
- Each synchronized button feeds a debounce counter.
- The filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples.
- Latency becomes 4+DEBOUNCE_CYCLES cycles.
REQ-027 With DRINK_VEND_DEBOUNCE_EN undefined, the filtered level equals the synchronized level; no debounce logic is instantiated.

Structure
REQ-028 Shared package drink_vend_pkg SHALL hold:
- the state enum (IDLE, SELECT, DISPENSE);
- the LED off constant (all 1s);
- the clog2-based width helper.
REQ-029 One sub-module, btn_debounce (synchronizer, optional filter, falling-edge detect), SHALL be instantiated once per button.

Verification
REQ-030 Default parameters, macro undefined, the bench SHALL cover:
- rst, then three btn1 presses -> sel_idx 1,2,3, lights 110,101,011.
- A fourth btn1 press -> sel_idx wraps to 1, lights 110.
- sel_idx=2, btn2 press -> dispensing high for 8 cycles, bit1 blinking, then vend_done one-cycle pulse, sel_idx=0, lights 111.
- btn1 and btn2 low together during DISPENSE -> next cycle IDLE, lights 111, no vend_done.
- btn2 press in IDLE -> no state change, lights stay 111.
- Macro defined, DEBOUNCE_CYCLES=4, a 3-cycle glitch on btn1 -> no event; a 6-cycle press -> sel_idx=1 at latency 8.
